// File: rtl/aplic_msi_sched.sv
// aplic_msi_sched: MSI-mode delivery scheduler for an APLIC interrupt domain.
// Picks one pending-and-enabled source per round, issues its MSI (hart index +
// EIID) over a valid/ready port, then pulses a pending-clear to the register
// file. Software genmsi writes share the same port and win over sources.
// Optional feature macro: APLIC_MSI_RR_EN (round-robin source selection);
// when undefined, the lowest-numbered candidate wins.
module aplic_msi_sched #(
    parameter int NR_SRC   = 32,
    parameter int NR_SRC_W = $clog2(NR_SRC)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ie,
    input  logic                   i_dm,
    input  logic [NR_SRC-1:0]      i_pending,
    input  logic [NR_SRC-1:0]      i_enabled,
    input  logic [14*NR_SRC-1:0]   i_target_hi,
    input  logic [11*NR_SRC-1:0]   i_target_eiid,
    input  logic                   i_genmsi_we,
    input  logic [13:0]            i_genmsi_hi,
    input  logic [10:0]            i_genmsi_eiid,
    output logic                   o_genmsi_busy,
    output logic                   o_msi_valid,
    input  logic                   i_msi_ready,
    output logic [13:0]            o_msi_hi,
    output logic [10:0]            o_msi_eiid,
    output logic                   o_clr_valid,
    output logic [NR_SRC_W-1:0]    o_clr_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CLR   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_msi_valid;
    logic                  r_clr_valid;
    logic [13:0]           r_msi_hi;
    logic [10:0]           r_msi_eiid;
    logic [NR_SRC_W-1:0]   r_clr_idx;
    logic                  r_is_gen;
    logic                  r_gen_busy;
    logic [13:0]           r_gen_hi;
    logic [10:0]           r_gen_eiid;

    logic [NR_SRC-1:0]     w_cand;
    logic                  w_sched_ok;
    logic                  w_sel_found;
    logic [NR_SRC_W-1:0]   w_sel_idx;
    logic [13:0]           w_sel_hi;
    logic [10:0]           w_sel_eiid;
    logic                  w_load_gen;
    logic                  w_load_src;
    logic                  w_gen_done;

    // Lowest set bit above source 0: {found, index}.
    function automatic logic [NR_SRC_W:0] f_first(input logic [NR_SRC-1:0] vec);
        logic [NR_SRC_W:0] res;
        res = {(NR_SRC_W+1){1'b0}};
        for (int k = NR_SRC - 1; k >= 1; k--) begin
            if (vec[k]) begin
                res = {1'b1, NR_SRC_W'(k)};
            end
        end
        return res;
    endfunction

    // Candidate sources: pending and enabled, source 0 never takes part.
    always_comb begin
        w_cand    = i_pending & i_enabled;
        w_cand[0] = 1'b0;
    end

    assign w_sched_ok = i_ie & i_dm;

`ifdef APLIC_MSI_RR_EN
    logic [NR_SRC_W-1:0] r_ptr;
    logic [NR_SRC-1:0]   w_upper;
    logic [NR_SRC_W:0]   w_pick_up;
    logic [NR_SRC_W:0]   w_pick_all;

    // Prefer candidates at or above the pointer, otherwise wrap to the lowest.
    always_comb begin
        for (int k = 0; k < NR_SRC; k++) begin
            w_upper[k] = w_cand[k] & (k >= int'(r_ptr));
        end
        w_pick_up  = f_first(w_upper);
        w_pick_all = f_first(w_cand);
        if (w_pick_up[NR_SRC_W]) begin
            {w_sel_found, w_sel_idx} = w_pick_up;
        end else begin
            {w_sel_found, w_sel_idx} = w_pick_all;
        end
    end

    // Pointer moves just past each selected source, wrapping back to 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= NR_SRC_W'(1);
        end else if (w_load_src) begin
            r_ptr <= (w_sel_idx == NR_SRC_W'(NR_SRC - 1)) ? NR_SRC_W'(1)
                                                          : w_sel_idx + NR_SRC_W'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    // Fixed priority: lowest-numbered candidate wins.
    always_comb begin
        {w_sel_found, w_sel_idx} = f_first(w_cand);
    end
`endif

    // Mux the selected source's target fields out of the flat buses.
    always_comb begin
        w_sel_hi   = 14'd0;
        w_sel_eiid = 11'd0;
        for (int k = 0; k < NR_SRC; k++) begin
            w_sel_hi   = w_sel_hi   | (i_target_hi[14*k +: 14]   & {14{w_sel_idx == NR_SRC_W'(k)}});
            w_sel_eiid = w_sel_eiid | (i_target_eiid[11*k +: 11] & {11{w_sel_idx == NR_SRC_W'(k)}});
        end
    end

    // Next-state logic; genmsi outranks sources, EIID 0 skips straight to clear.
    always_comb begin
        w_state_nxt = r_state;
        w_load_gen  = 1'b0;
        w_load_src  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_gen_busy && i_dm) begin
                    w_load_gen  = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else if (w_sched_ok && w_sel_found) begin
                    w_load_src  = 1'b1;
                    w_state_nxt = (w_sel_eiid == 11'd0) ? ST_CLR : ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i_msi_ready) begin
                    w_state_nxt = r_is_gen ? ST_IDLE : ST_CLR;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_CLR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_gen_done = (r_state == ST_ISSUE) & r_is_gen & i_msi_ready;

    // State register plus registered valid/clear strobes decoded from next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_msi_valid <= 1'b0;
            r_clr_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_msi_valid <= (w_state_nxt == ST_ISSUE);
            r_clr_valid <= (w_state_nxt == ST_CLR);
        end
    end

    // Request payload is captured at selection and held until the next one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_msi_hi   <= 14'd0;
            r_msi_eiid <= 11'd0;
            r_clr_idx  <= {NR_SRC_W{1'b0}};
            r_is_gen   <= 1'b0;
        end else if (w_load_gen) begin
            r_msi_hi   <= r_gen_hi;
            r_msi_eiid <= r_gen_eiid;
            r_is_gen   <= 1'b1;
        end else if (w_load_src) begin
            r_msi_hi   <= w_sel_hi;
            r_msi_eiid <= w_sel_eiid;
            r_clr_idx  <= w_sel_idx;
            r_is_gen   <= 1'b0;
        end else begin
            r_is_gen   <= r_is_gen;
        end
    end

    // genmsi holding register: accepts a write only when not already busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gen_busy <= 1'b0;
            r_gen_hi   <= 14'd0;
            r_gen_eiid <= 11'd0;
        end else if (w_gen_done) begin
            r_gen_busy <= 1'b0;
        end else if (i_genmsi_we && !r_gen_busy) begin
            r_gen_busy <= 1'b1;
            r_gen_hi   <= i_genmsi_hi;
            r_gen_eiid <= i_genmsi_eiid;
        end else begin
            r_gen_busy <= r_gen_busy;
        end
    end

    assign o_genmsi_busy = r_gen_busy;
    assign o_msi_valid   = r_msi_valid;
    assign o_msi_hi      = r_msi_hi;
    assign o_msi_eiid    = r_msi_eiid;
    assign o_clr_valid   = r_clr_valid;
    assign o_clr_idx     = r_clr_idx;

endmodule

// File: tb/tb_aplic_msi_sched.sv
// Testbench for aplic_msi_sched (NR_SRC = 32): vector table, hand sequences
// for stall / genmsi / reset / ordering, and a randomized phase checked by a
// transaction-level reference model.
module tb_aplic_msi_sched;

    localparam int NS = 32;
    localparam int NW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              ie, dm;
    logic [NS-1:0]     pending, enabled;
    logic [14*NS-1:0]  tgt_hi;
    logic [11*NS-1:0]  tgt_eiid;
    logic              gen_we;
    logic [13:0]       gen_hi;
    logic [10:0]       gen_eiid;
    logic              busy;
    logic              msi_valid, msi_ready;
    logic [13:0]       msi_hi;
    logic [10:0]       msi_eiid;
    logic              clr_valid;
    logic [NW-1:0]     clr_idx;

    logic [13:0]       tb_hi   [NS];
    logic [10:0]       tb_eiid [NS];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            tgt_hi[14*k +: 14]   = tb_hi[k];
            tgt_eiid[11*k +: 11] = tb_eiid[k];
        end
    end

    aplic_msi_sched #(.NR_SRC(NS)) dut (
        .i_clk(clk), .i_rst(rst), .i_ie(ie), .i_dm(dm),
        .i_pending(pending), .i_enabled(enabled),
        .i_target_hi(tgt_hi), .i_target_eiid(tgt_eiid),
        .i_genmsi_we(gen_we), .i_genmsi_hi(gen_hi), .i_genmsi_eiid(gen_eiid),
        .o_genmsi_busy(busy), .o_msi_valid(msi_valid), .i_msi_ready(msi_ready),
        .o_msi_hi(msi_hi), .o_msi_eiid(msi_eiid),
        .o_clr_valid(clr_valid), .o_clr_idx(clr_idx)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; pending = '0; gen_we = 1'b0; msi_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0; ie = 1'b1; dm = 1'b1; enabled = 32'hFFFF_FFFF;
    endtask

    // Reference selection: circular search from the pointer (or from 1).
    function automatic int ref_pick(input logic [31:0] c, input int ptr);
`ifdef APLIC_MSI_RR_EN
        for (int off = 0; off < NS - 1; off++) begin
            int k;
            k = 1 + ((ptr - 1 + off) % (NS - 1));
            if (c[k]) return k;
        end
`else
        for (int k = 1; k < NS; k++) begin
            if (c[k]) return k;
        end
`endif
        return -1;
    endfunction

    typedef struct {
        logic [31:0] pend;
        logic [31:0] en;
        logic        ie;
        logic        dm;
        int          kind;   // 0 nothing, 1 MSI, 2 drop (EIID 0)
        int          idx;
    } vec_t;

    vec_t tbl[10];

    // random-phase model state
    int          r_ptr_m, inflight, k_exp, got;
    logic [31:0] pend_m, cur_cand, prev_cand;
    logic        prev_valid, prev_ready, prev_clr, prev_allowed, start, exp_start, hs_prev;
    logic [4:0]  prev_clr_idx;
    logic [13:0] prev_hi;
    logic [10:0] prev_eiid;
    int          order_q[$];
    int          exp_order[4];

    initial begin
        for (int k = 0; k < NS; k++) begin
            tb_hi[k]   = 14'(k + 3);
            tb_eiid[k] = 11'(k * 2 + 16);
        end
        tb_hi[5] = 14'd3; tb_eiid[5] = 11'h21; tb_eiid[7] = 11'd0;
        rst = 1'b1; ie = 1'b1; dm = 1'b1; pending = '0; enabled = 32'hFFFF_FFFF;
        gen_we = 1'b0; gen_hi = '0; gen_eiid = '0; msi_ready = 1'b1;

        // reset state
        smp();
        chk("rst_valid", msi_valid, 0); chk("rst_hi", msi_hi, 0); chk("rst_eiid", msi_eiid, 0);
        chk("rst_clr", clr_valid, 0); chk("rst_idx", clr_idx, 0); chk("rst_busy", busy, 0);
        cyc(); rst = 1'b0;
        cyc();

        // vector table (order keeps round-robin and fixed priority in agreement)
        tbl[0] = '{32'h0000_0020, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 5};
        tbl[1] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1, 0, 0};
        tbl[2] = '{32'h0000_0040, 32'h0000_0000, 1'b1, 1'b1, 0, 0};
        tbl[3] = '{32'h0000_0240, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 0};
        tbl[4] = '{32'h0000_0240, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0};
        tbl[5] = '{32'h0000_0240, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 6};
        tbl[6] = '{32'h0000_0080, 32'hFFFF_FFFF, 1'b1, 1'b1, 2, 7};
        tbl[7] = '{32'h8000_0100, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 8};
        tbl[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 31};
        tbl[9] = '{32'h0010_0002, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            pending = tbl[i].pend; enabled = tbl[i].en; ie = tbl[i].ie; dm = tbl[i].dm;
            msi_ready = 1'b1;
            cyc(); pending = '0;
            smp();
            chk($sformatf("v%0d_valid", i), msi_valid, tbl[i].kind == 1);
            chk($sformatf("v%0d_clr", i), clr_valid, tbl[i].kind == 2);
            if (tbl[i].kind == 1) begin
                chk($sformatf("v%0d_hi", i), msi_hi, tb_hi[tbl[i].idx]);
                chk($sformatf("v%0d_eiid", i), msi_eiid, tb_eiid[tbl[i].idx]);
            end
            if (tbl[i].kind == 2) chk($sformatf("v%0d_drop_idx", i), clr_idx, tbl[i].idx);
            cyc(); smp();
            if (tbl[i].kind == 1) begin
                chk($sformatf("v%0d_clr2", i), clr_valid, 1);
                chk($sformatf("v%0d_idx2", i), clr_idx, tbl[i].idx);
            end
            chk($sformatf("v%0d_nomsi2", i), msi_valid, 0);
            ie = 1'b1; dm = 1'b1; enabled = 32'hFFFF_FFFF;
            cyc(); cyc();
        end

        // stall: payload stable and not retracted while ready is low
        msi_ready = 1'b0; pending = 32'h20;
        for (int j = 0; j < 10; j++) begin
            cyc(); smp();
            chk("stall_valid", msi_valid, 1); chk("stall_hi", msi_hi, 3); chk("stall_eiid", msi_eiid, 11'h21);
        end
        cyc(); ie = 1'b0; pending = '0; smp();
        chk("noretract_valid", msi_valid, 1); chk("noretract_eiid", msi_eiid, 11'h21);
        cyc(); msi_ready = 1'b1; smp();
        chk("stall_hs_valid", msi_valid, 1);
        cyc(); smp();
        chk("stall_clr", clr_valid, 1); chk("stall_clr_idx", clr_idx, 5); chk("stall_after_valid", msi_valid, 0);
        cyc(); ie = 1'b1; smp();
        chk("stall_clr_once", clr_valid, 0); chk("stall_no_second", msi_valid, 0);

        // genmsi: first write issued ahead of a source, second write ignored
        cyc(); msi_ready = 1'b0; gen_we = 1'b1; gen_hi = 14'd1; gen_eiid = 11'h40; smp();
        chk("gen_busy0", busy, 0);
        cyc(); gen_hi = 14'd2; gen_eiid = 11'h55; pending = 32'h20; smp();
        chk("gen_busy1", busy, 1); chk("gen_novalid", msi_valid, 0);
        cyc(); gen_we = 1'b0; smp();
        chk("gen_valid", msi_valid, 1); chk("gen_hi", msi_hi, 1); chk("gen_eiid", msi_eiid, 11'h40); chk("gen_busy2", busy, 1);
        cyc(); smp();
        chk("gen_hold_eiid", msi_eiid, 11'h40); chk("gen_busy3", busy, 1);
        cyc(); msi_ready = 1'b1; smp();
        chk("gen_hs_valid", msi_valid, 1);
        cyc(); smp();
        chk("gen_busy_clr", busy, 0); chk("gen_no_clr", clr_valid, 0); chk("gen_idle", msi_valid, 0);
        cyc(); smp();
        chk("gen_src_valid", msi_valid, 1); chk("gen_src_hi", msi_hi, 3); chk("gen_src_eiid", msi_eiid, 11'h21);
        cyc(); pending = '0; smp();
        chk("gen_src_clr", clr_valid, 1); chk("gen_src_idx", clr_idx, 5);
        for (int j = 0; j < 3; j++) begin
            cyc(); smp(); chk("gen_no_second", msi_valid, 0);
        end

        // same-cycle genmsi write and source selection, then reset mid-ISSUE
        cyc(); msi_ready = 1'b0; gen_we = 1'b1; gen_hi = 14'h3ff; gen_eiid = 11'h7; pending = 32'h20;
        cyc(); gen_we = 1'b0; smp();
        chk("tie_src_first", msi_eiid, 11'h21); chk("tie_valid", msi_valid, 1); chk("tie_busy", busy, 1);
        @(posedge clk); #2 rst = 1'b1; #1;
        chk("arst_valid", msi_valid, 0); chk("arst_hi", msi_hi, 0); chk("arst_eiid", msi_eiid, 0);
        chk("arst_clr", clr_valid, 0); chk("arst_idx", clr_idx, 0); chk("arst_busy", busy, 0);
        cyc(); rst = 1'b0; msi_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 10 && got == 0; t++) begin
            smp();
            if (msi_valid) begin
                got = 1;
                chk("resume_hi", msi_hi, 3); chk("resume_eiid", msi_eiid, 11'h21);
            end
            cyc();
        end
        if (got == 0) chk("resume_timeout", 0, 1);
        pending = '0;
        for (int j = 0; j < 4; j++) begin
            smp(); chk("gen_discarded", msi_valid && msi_eiid == 11'h7, 0); chk("gen_discard_busy", busy, 0);
            cyc();
        end

        // delivery order with 2, 4, 9 held pending (register file re-pends)
        do_reset();
        msi_ready = 1'b1; pending = 32'h0000_0214;
`ifdef APLIC_MSI_RR_EN
        exp_order = '{2, 4, 9, 2};
`else
        exp_order = '{2, 2, 2, 2};
`endif
        order_q.delete();
        for (int t = 0; t < 60 && order_q.size() < 4; t++) begin
            smp();
            if (clr_valid) order_q.push_back(int'(clr_idx));
            cyc();
        end
        if (order_q.size() < 4) chk("order_timeout", order_q.size(), 4);
        for (int i = 0; i < order_q.size() && i < 4; i++) chk($sformatf("order_%0d", i), order_q[i], exp_order[i]);

        // randomized phase against the transaction-level model
        do_reset();
        for (int k = 0; k < NS; k++) begin
            tb_hi[k]   = 14'($urandom_range(0, 16383));
            tb_eiid[k] = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
        end
        pend_m = '0; r_ptr_m = 1; inflight = -1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_clr = 1'b0; prev_clr_idx = '0;
        prev_cand = '0; prev_allowed = 1'b0; prev_hi = '0; prev_eiid = '0;
        for (int t = 0; t < 400; t++) begin
            cyc();
            if (prev_clr) pend_m[prev_clr_idx] = 1'b0;
            if ($urandom_range(0, 2) == 0) pend_m[$urandom_range(1, NS - 1)] = 1'b1;
            pend_m[0] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) enabled = $urandom;
            ie = ($urandom_range(0, 7) != 0);
            dm = ($urandom_range(0, 15) != 0);
            msi_ready = 1'($urandom_range(0, 1));
            pending = pend_m;
            smp();
            cur_cand = pend_m & enabled & 32'hFFFF_FFFE;
            hs_prev = prev_valid && prev_ready;
            start = (msi_valid && !prev_valid) || (clr_valid && !hs_prev);
            exp_start = !prev_valid && !prev_clr && prev_allowed && (prev_cand != 0);
            chk("rnd_start", start, exp_start);
            if (start && exp_start) begin
                k_exp = ref_pick(prev_cand, r_ptr_m);
                if (msi_valid) begin
                    chk("rnd_hi", msi_hi, tb_hi[k_exp]); chk("rnd_eiid", msi_eiid, tb_eiid[k_exp]);
                    inflight = k_exp;
                end else begin
                    chk("rnd_drop_idx", clr_idx, k_exp); chk("rnd_drop_eiid0", tb_eiid[k_exp], 0);
                end
                r_ptr_m = 1 + (k_exp % (NS - 1));
            end
            if (hs_prev) begin
                chk("rnd_clr_after_hs", clr_valid, 1); chk("rnd_clr_idx", clr_idx, inflight);
            end
            if (prev_valid && !prev_ready) begin
                chk("rnd_hold_valid", msi_valid, 1); chk("rnd_hold_hi", msi_hi, prev_hi); chk("rnd_hold_eiid", msi_eiid, prev_eiid);
            end
            prev_valid = msi_valid; prev_ready = msi_ready; prev_clr = clr_valid; prev_clr_idx = clr_idx;
            prev_cand = cur_cand; prev_allowed = ie && dm; prev_hi = msi_hi; prev_eiid = msi_eiid;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
